// File: rtl/lm32_tlb_walker_if.sv
// Wishbone master port of the TLB refill walker (single-beat PTE reads).
interface lm32_tlb_walker_if;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/lm32_tlb_walker.sv
// Shared ITLB/DTLB refill walker: round-robin arbitration between miss
// requests, one PTE read over Wishbone, TLB update strobe, done/fault pulse.
module lm32_tlb_walker #(
  parameter int page_size      = 4096,
  parameter int timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable,
  input  logic [31:0] ptbr,
  input  logic        imiss_req,
  input  logic [31:0] imiss_vaddr,
  input  logic        dmiss_req,
  input  logic [31:0] dmiss_vaddr,
  input  logic        abort,
  output logic        i_done,
  output logic        d_done,
  output logic        i_fault,
  output logic        d_fault,
  output logic [31:0] fault_addr,
  output logic [31:0] tlb_wr_vaddr,
  output logic [31:0] tlb_wr_paddr,
  output logic        itlb_wr,
  output logic        dtlb_wr,
  output logic        busy,
  lm32_tlb_walker_if.master wb
);
  localparam int OFFS = $clog2(page_size);
  localparam int TW   = $clog2(timeout_cycles + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(timeout_cycles);

  typedef enum logic [2:0] {IDLE, FETCH, UPDATE, RESP, DRAIN} state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;        // 1: favour D on a tie
  logic             sel_q, sel_d;      // latched requester, 1 = D
  logic             flt_q, flt_d;
  logic [31:0]      vaddr_q, vaddr_d;
  logic [31:OFFS]   pfn_q, pfn_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [31:0]      faddr_q, faddr_d;
  logic             gnt_d;
  logic             term;

  // Bus termination of any kind ends the read, whether or not it was aborted.
  assign term = wb.wb_ack_i || wb.wb_err_i || (tmo_q == TMO_MAX);

  // State and datapath registers; async reset drops the bus at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      sel_q   <= 1'b0;
      flt_q   <= 1'b0;
      vaddr_q <= '0;
      pfn_q   <= '0;
      tmo_q   <= '0;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      flt_q   <= flt_d;
      vaddr_q <= vaddr_d;
      pfn_q   <= pfn_d;
      tmo_q   <= tmo_d;
      faddr_q <= faddr_d;
    end
  end

  // Next-state logic: grant, fetch/timeout, update, respond, drain.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    flt_d   = flt_q;
    vaddr_d = vaddr_q;
    pfn_d   = pfn_q;
    tmo_d   = tmo_q;
    faddr_d = faddr_q;
    gnt_d   = dmiss_req && (!imiss_req || rr_q);
    unique case (state_q)
      IDLE: begin
        if (enable && !abort && (imiss_req || dmiss_req)) begin
          sel_d   = gnt_d;
          vaddr_d = gnt_d ? dmiss_vaddr : imiss_vaddr;
          rr_d    = !gnt_d;            // next tie goes to the side not just served
          flt_d   = 1'b0;
          tmo_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        tmo_d = tmo_q + 1'b1;
        if (term) begin
          // err beats ack; an aborted walk that terminates now just goes idle
          if (wb.wb_err_i || !wb.wb_ack_i || !wb.wb_dat_i[0]) begin
            flt_d   = 1'b1;
            state_d = abort ? IDLE : RESP;
          end else begin
            pfn_d   = wb.wb_dat_i[31:OFFS];
            state_d = abort ? IDLE : UPDATE;
          end
        end else if (abort) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        tmo_d = tmo_q + 1'b1;
        if (term) state_d = IDLE;
      end
      UPDATE: state_d = RESP;
      RESP: begin
        if (flt_q) faddr_d = vaddr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic cyc;
  assign cyc = (state_q == FETCH) || (state_q == DRAIN);

  assign wb.wb_cyc_o = cyc;
  assign wb.wb_stb_o = cyc;
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_sel_o = 4'hF;
  assign wb.wb_adr_o = cyc ? {ptbr[31:22], vaddr_q[31:12], 2'b00} : '0;

  assign busy         = (state_q != IDLE);
  assign itlb_wr      = (state_q == UPDATE) && !sel_q;
  assign dtlb_wr      = (state_q == UPDATE) &&  sel_q;
  assign tlb_wr_vaddr = (state_q == UPDATE) ? {vaddr_q[31:OFFS], {(OFFS-1){1'b0}}, 1'b1} : '0;
  assign tlb_wr_paddr = (state_q == UPDATE) ? {pfn_q, {(OFFS-1){1'b0}}, 1'b1} : '0;
  assign i_done       = (state_q == RESP) && !sel_q && !flt_q;
  assign d_done       = (state_q == RESP) &&  sel_q && !flt_q;
  assign i_fault      = (state_q == RESP) && !sel_q &&  flt_q;
  assign d_fault      = (state_q == RESP) &&  sel_q &&  flt_q;
  assign fault_addr   = faddr_q;

  logic unused_ok;
  assign unused_ok = ^{ptbr[21:0], wb.wb_dat_i[OFFS-1:1]};
endmodule

// File: doc/lm32_tlb_walker.md
Name: lm32_tlb_walker

Overview:
- Hardware refill sequencer shared by the instruction TLB and data TLB under CFG_MMU_ENABLED.
- Accepts miss requests from both TLBs and arbitrates between them round-robin.
- For the winning request, fetches one page-table entry (PTE) over a Wishbone master port and writes the translation into the requesting TLB through its update port.
- Signals done or fault back to the requester; it sits beside lm32_itlb/lm32_dtlb, and its bus port is shared upstream with the data bus.

Parameters:
- page_size, 4096: system page size; offset bits = CLOG2(page_size) (=12).
- timeout_cycles, 255: maximum cycles to wait for ack/err before declaring a fault; counter width = CLOG2(timeout_cycles+1).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous, active-low reset
- enable  in  1  walker enable; when 0, requests are ignored (no grant)
- ptbr  in  32  page-table base; only bits [31:22] are used (table is 4 MB aligned)
- imiss_req  in  1  ITLB miss request, level, held until done/fault
- imiss_vaddr  in  32  ITLB miss virtual address
- dmiss_req  in  1  DTLB miss request, level, held until done/fault
- dmiss_vaddr  in  32  DTLB miss virtual address
- abort  in  1  exception/eret flush; cancels the walk in progress
- i_done / d_done  out  1 each  one-cycle pulse: refill completed
- i_fault / d_fault  out  1 each  one-cycle pulse: invalid PTE, bus error or timeout
- fault_addr  out  32  vaddr of the last faulted walk; held until the next fault
- tlb_wr_vaddr  out  32  update virtual address; bit0 = 1, [5:1] = 0
- tlb_wr_paddr  out  32  update physical address; {PFN, offset zeros} with bit0 = 1
- itlb_wr / dtlb_wr  out  1 each  one-cycle write strobe to the ITLB/DTLB update port
- busy  out  1  walker not IDLE
- wb_adr_o  out  32  PTE address
- wb_cyc_o, wb_stb_o  out  1  bus cycle/strobe
- wb_we_o  out  1  constant 0
- wb_sel_o  out  4  constant 4'hF
- wb_dat_i  in  32  read data
- wb_ack_i, wb_err_i  in  1  bus termination

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer favours I; fault_addr = 0.
- States:
  - IDLE
  - FETCH
  - UPDATE
  - RESP
  - DRAIN (aborted walk waiting for termination)
- IDLE:
  - If enable and any request, grant one and latch its vaddr and requester ID.
  - If both requests are pending, grant the side not served last; the pointer flips after every grant.
  - Next state FETCH.
- FETCH:
  - Drive wb_cyc_o = wb_stb_o = 1, wb_adr_o = {ptbr[31:22], vaddr[31:12], 2'b00}.
  - First bus cycle is the cycle after the grant.
  - Timeout counter clears on entry and increments each cycle.
  - On ack or err, drop cyc/stb in the same cycle as sampling.
  - ack with wb_dat_i[0] = 1 → latch the PTE, go to UPDATE.
  - ack with bit0 = 0, err, or counter = timeout_cycles → set fault, go to RESP.
  - Simultaneous ack and err: err wins.
- UPDATE:
  - One cycle.
  - tlb_wr_vaddr = {vaddr[31:12], 11'd0, 1'b1}; tlb_wr_paddr = {pte[31:12], 11'd0, 1'b1}.
  - Pulse itlb_wr or dtlb_wr according to the latched requester; next state RESP.
- RESP:
  - One cycle; pulse x_done, or x_fault with fault_addr <= vaddr.
  - Next state IDLE; a new grant is possible no earlier than the following cycle.
  - Minimum latency from request to done = 4 cycles with a zero-wait ack.
- abort:
  - In FETCH, the bus cycle is kept asserted until ack/err/timeout (DRAIN), then the walker returns to IDLE with no TLB write, no done and no fault.
  - In UPDATE or RESP, the current cycle completes normally.
  - In IDLE, abort suppresses the grant for that cycle.
- A requester dropping its request mid-walk has no effect; the walk completes and its pulse is still issued.
- enable falling mid-walk has no effect until IDLE.
- Asynchronous reset mid-walk: the bus is released immediately (cyc = 0) and no strobes are issued.
- Exactly one of itlb_wr/dtlb_wr/done/fault is active per walk; never both i and d outputs in the same cycle.

Test Plan:
- DTLB miss only, ptbr = 0x0040_0000, dmiss_vaddr = 0x1234_5678, zero-wait ack with data 0x0ABC_D001 → wb_adr_o = 0x0044_8D14; dtlb_wr with tlb_wr_vaddr = 0x1234_5001, tlb_wr_paddr = 0x0ABC_D001; d_done 4 cycles after the request.
- imiss_req and dmiss_req asserted together, twice in succession → first grant I, second grant D; no overlapping bus cycles.
- PTE data 0x0ABC_D000 (invalid) → no TLB write; d_fault pulse; fault_addr = dmiss_vaddr.
- No ack for 255 cycles → i_fault at timeout; cyc drops; busy clears the next cycle.
- abort asserted during FETCH with ack after 3 wait cycles → cyc held until ack; no wr, done or fault pulse; busy = 0 after.
- rst_n_i pulsed low during FETCH → wb_cyc_o = 0 asynchronously; all outputs 0; the next request is walked normally.
